msrv_32_branch_ctrl: RTL

MSRV_32_BRANCH_CTRL -- requirements
Module: msrv_32_branch_ctrl

---
 rtl/msrv_32_pkg.sv | 22 ++
 rtl/msrv_32_branch_perf_ctr.sv | 33 +++
 rtl/msrv_32_branch_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/msrv_32_pkg.sv
// Shared constants for the msrv_32 branch/fetch control slice: opcode
// classes, FSM state encoding and flush-counter sizing.
package msrv_32_pkg;

    localparam logic [4:0] OPC_BRN  = 5'b11000;
    localparam logic [4:0] OPC_JAL  = 5'b11011;
    localparam logic [4:0] OPC_JALR = 5'b11001;

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_TRAP  = 2'd3
    } state_e;

    function automatic logic is_ctrl_xfer(input logic [4:0] opc);
        return (opc == OPC_BRN) || (opc == OPC_JAL) || (opc == OPC_JALR);
    endfunction

endpackage

// File: rtl/msrv_32_branch_perf_ctr.sv
// Branch statistics counters; instantiated by msrv_32_branch_ctrl only when
// MSRV_32_BRANCH_PERF_EN is defined. Both counters wrap modulo 2^32.
module msrv_32_branch_perf_ctr (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        brn_evt_in,
    input  logic        taken_evt_in,
    output logic [31:0] branch_count_out,
    output logic [31:0] taken_count_out
);

    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] taken_cnt_q,  taken_cnt_d;

    always_comb begin
        branch_cnt_d = branch_cnt_q + {31'd0, brn_evt_in};
        taken_cnt_d  = taken_cnt_q  + {31'd0, taken_evt_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q <= 32'd0;
            taken_cnt_q  <= 32'd0;
        end else begin
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
        end
    end

    assign branch_count_out = branch_cnt_q;
    assign taken_count_out  = taken_cnt_q;

endmodule

// File: rtl/msrv_32_branch_ctrl.sv
// Fetch-PC sequencer with branch redirect, IF/ID flush and misaligned-target
// trap. Define MSRV_32_BRANCH_PERF_EN to add branch/taken statistics counters.
module msrv_32_branch_ctrl
    import msrv_32_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_n_in,
    input  logic        branch_taken_in,
    input  logic [4:0]  opcode_6_to_2_in,
    input  logic [31:0] target_addr_in,
    input  logic        instr_valid_in,
    input  logic        imem_ready_in,
    input  logic        stall_in,
    input  logic        trap_ack_in,
    output logic [31:0] pc_out,
    output logic        fetch_req_out,
    output logic        flush_out,
    output logic        misaligned_instr_out
`ifdef MSRV_32_BRANCH_PERF_EN
    ,
    output logic [31:0] branch_count_out,
    output logic [31:0] taken_count_out
`endif
);

    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      eff_tgt;
    logic [31:0]      pc_seq;
    logic             redirect;

    assign eff_tgt  = {target_addr_in[31:1], 1'b0};
    assign pc_seq   = imem_ready_in ? (pc_q + 32'd4) : pc_q;
    assign redirect = (state_q == ST_RUN) && instr_valid_in && branch_taken_in && !stall_in;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN: begin
                if (redirect) begin
                    // A target that is not word aligned after clearing bit 0 traps.
                    if (eff_tgt[1]) begin
                        state_d = ST_TRAP;
                    end else begin
                        pc_d    = eff_tgt;
                        state_d = ST_FLUSH;
                        cnt_d   = FLUSH_LOAD;
                    end
                end else if (!stall_in) begin
                    pc_d = pc_seq;
                end
            end
            ST_FLUSH: begin
                if (!stall_in) begin
                    pc_d  = pc_seq;
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_TRAP: begin
                // Stall does not hold the trap; only the acknowledge matters.
                if (trap_ack_in) begin
                    pc_d    = TRAP_VECTOR;
                    state_d = ST_FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            state_q <= ST_IDLE;
            pc_q    <= BOOT_ADDR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc_out               = pc_q;
    assign fetch_req_out        = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    assign flush_out            = (state_q == ST_FLUSH) || (state_q == ST_TRAP);
    assign misaligned_instr_out = (state_q == ST_TRAP);

    // Opcode never steers control flow; this sink keeps it and bit 0 of the target referenced.
    logic info_unused;
    assign info_unused = is_ctrl_xfer(opcode_6_to_2_in) ^ target_addr_in[0];

`ifdef MSRV_32_BRANCH_PERF_EN
    logic brn_evt;
    assign brn_evt = (state_q == ST_RUN) && instr_valid_in && !stall_in &&
                     (opcode_6_to_2_in == OPC_BRN);

    msrv_32_branch_perf_ctr u_perf (
        .clk              (ms_riscv32_mp_clk_in),
        .rst_n            (ms_riscv32_mp_rst_n_in),
        .brn_evt_in       (brn_evt),
        .taken_evt_in     (redirect),
        .branch_count_out (branch_count_out),
        .taken_count_out  (taken_count_out)
    );
`endif

endmodule
